// File: rtl/frontend_arbiter.sv
// Two-requester round-robin arbiter in front of the Frontend command,
// store-data and return-data channels; one transaction in flight.
module frontend_arbiter #(
  parameter int ORAMU      = 32,
  parameter int ORAMB      = 512,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2,
  parameter int DMWidth    = ORAMB / 8
) (
  input  logic                  Clock,
  input  logic                  Reset,

  output logic                  CmdInReady_0,
  input  logic                  CmdInValid_0,
  input  logic [BECMDWidth-1:0] CmdIn_0,
  input  logic [ORAMU-1:0]      ProgAddrIn_0,
  input  logic [DMWidth-1:0]    WMaskIn_0,
  output logic                  DataInReady_0,
  input  logic                  DataInValid_0,
  input  logic [FEDWidth-1:0]   DataIn_0,
  input  logic                  ReturnDataReady_0,
  output logic                  ReturnDataValid_0,
  output logic [FEDWidth-1:0]   ReturnData_0,

  output logic                  CmdInReady_1,
  input  logic                  CmdInValid_1,
  input  logic [BECMDWidth-1:0] CmdIn_1,
  input  logic [ORAMU-1:0]      ProgAddrIn_1,
  input  logic [DMWidth-1:0]    WMaskIn_1,
  output logic                  DataInReady_1,
  input  logic                  DataInValid_1,
  input  logic [FEDWidth-1:0]   DataIn_1,
  input  logic                  ReturnDataReady_1,
  output logic                  ReturnDataValid_1,
  output logic [FEDWidth-1:0]   ReturnData_1,

  input  logic                  CmdOutReady,
  output logic                  CmdOutValid,
  output logic [BECMDWidth-1:0] CmdOut,
  output logic [ORAMU-1:0]      ProgAddrOut,
  output logic [DMWidth-1:0]    WMaskOut,

  input  logic                  DataOutReady,
  output logic                  DataOutValid,
  output logic [FEDWidth-1:0]   DataOut,

  output logic                  FEReturnReady,
  input  logic                  FEReturnValid,
  input  logic [FEDWidth-1:0]   FEReturnData
);

  localparam int Beats = ORAMB / FEDWidth;
  localparam int BCW   = $clog2(Beats);

  localparam logic [BECMDWidth-1:0] BECMD_Update  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] BECMD_Append  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] BECMD_Read    = BECMDWidth'(2);
  localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StRet
  } state_t;

  typedef struct packed {
    logic [BECMDWidth-1:0] cmd;
    logic [ORAMU-1:0]      addr;
    logic [DMWidth-1:0]    mask;
  } cmdReg_t;

  state_t         stateQ, stateNext;
  logic [BCW-1:0] beatQ, beatNext;
  logic           lastQ, lastNext;
  logic           ownerQ, ownerNext;
  cmdReg_t        cmdQ, cmdNext;

  logic anyVld;
  logic winner;
  logic isStore;
  logic ownVld;
  logic beatHs;

  assign anyVld = CmdInValid_0 | CmdInValid_1;
  // With both valid, the one not granted last wins.
  assign winner = (CmdInValid_0 & CmdInValid_1)
                ? ~lastQ : CmdInValid_1;

  assign isStore = (cmdQ.cmd == BECMD_Update) |
                   (cmdQ.cmd == BECMD_Append);

  assign ownVld = ownerQ ? DataInValid_1 : DataInValid_0;

  assign CmdOut      = cmdQ.cmd;
  assign ProgAddrOut = cmdQ.addr;
  assign WMaskOut    = cmdQ.mask;

  assign DataOut      = ownerQ ? DataIn_1 : DataIn_0;
  assign ReturnData_0 = FEReturnData;
  assign ReturnData_1 = FEReturnData;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ <= StIdle;
      beatQ  <= '0;
      lastQ  <= 1'b1;
      ownerQ <= 1'b0;
      cmdQ   <= '0;
    end else begin
      stateQ <= stateNext;
      beatQ  <= beatNext;
      lastQ  <= lastNext;
      ownerQ <= ownerNext;
      cmdQ   <= cmdNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    beatNext  = beatQ;
    lastNext  = lastQ;
    ownerNext = ownerQ;
    cmdNext   = cmdQ;
    beatHs    = 1'b0;

    CmdInReady_0      = 1'b0;
    CmdInReady_1      = 1'b0;
    CmdOutValid       = 1'b0;
    DataOutValid      = 1'b0;
    DataInReady_0     = 1'b0;
    DataInReady_1     = 1'b0;
    FEReturnReady     = 1'b0;
    ReturnDataValid_0 = 1'b0;
    ReturnDataValid_1 = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (anyVld) begin
          if (winner) begin
            CmdInReady_1 = 1'b1;
            cmdNext = {CmdIn_1, ProgAddrIn_1, WMaskIn_1};
          end else begin
            CmdInReady_0 = 1'b1;
            cmdNext = {CmdIn_0, ProgAddrIn_0, WMaskIn_0};
          end
          ownerNext = winner;
          lastNext  = winner;
          stateNext = StCmd;
        end
      end
      StCmd: begin
        CmdOutValid = 1'b1;
        if (CmdOutReady)
          stateNext = isStore ? StData : StRet;
      end
      StData: begin
        DataOutValid  = ownVld;
        DataInReady_0 = ~ownerQ & DataOutReady;
        DataInReady_1 =  ownerQ & DataOutReady;
        beatHs        = ownVld & DataOutReady;
      end
      StRet: begin
        FEReturnReady = ownerQ ? ReturnDataReady_1
                               : ReturnDataReady_0;
        ReturnDataValid_0 = ~ownerQ & FEReturnValid;
        ReturnDataValid_1 =  ownerQ & FEReturnValid;
        beatHs = FEReturnValid & FEReturnReady;
      end
      default: stateNext = StIdle;
    endcase

    if (beatHs) begin
      if (beatQ == BCW'(Beats - 1)) begin
        beatNext  = '0;
        stateNext = StIdle;
      end else begin
        beatNext = beatQ + BCW'(1);
      end
    end
  end

  logic unusedRd;
  assign unusedRd = ^{BECMD_Read, BECMD_ReadRmv};

endmodule

// File: doc/frontend_arbiter.md
# frontend_arbiter

Two-requester arbiter that shares the single Frontend (UORAM + optional integrity verifier) command, store-data and return-data channels between two network-side clients, e.g. a processor port and a debug/host loader. One transaction is in flight at a time. The block grants the Frontend to one requester, holds that grant for the command, all of its data beats and, for reads, all return beats. It then releases the grant and re-arbitrates round-robin. It sits directly in front of the Frontend's CmdIn/DataIn/ReturnData ports.

## Interface
- ORAMU, 32, program address width
- ORAMB, 512, block size in bits
- FEDWidth, 64, data beat width; ORAMB divisible by FEDWidth; Beats = ORAMB/FEDWidth (≥2)
- BECMDWidth, 2, command width; encodings BECMD_Update, BECMD_Append, BECMD_Read, BECMD_ReadRmv from CommandsLocal.vh
- DMWidth, ORAMB/8, write-mask width
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- CmdInReady_0/1  out  1  per-requester command ready
- CmdInValid_0/1  in  1  per-requester command valid
- CmdIn_0/1  in  BECMDWidth  command
- ProgAddrIn_0/1  in  ORAMU  program address
- WMaskIn_0/1  in  DMWidth  write mask
- DataInReady_0/1  out  1  store-data ready
- DataInValid_0/1  in  1  store-data valid
- DataIn_0/1  in  FEDWidth  store-data beat
- ReturnDataReady_0/1  in  1  requester accepts return beat
- ReturnDataValid_0/1  out  1  return beat valid
- ReturnData_0/1  out  FEDWidth  return beat
- CmdOutReady  in  1  Frontend CmdInReady
- CmdOutValid  out  1  to Frontend CmdInValid
- CmdOut  out  BECMDWidth  to Frontend CmdIn
- ProgAddrOut  out  ORAMU  to Frontend ProgAddrIn
- WMaskOut  out  DMWidth  to Frontend WMaskIn
- DataOutReady  in  1  Frontend DataInReady
- DataOutValid  out  1  to Frontend DataInValid
- DataOut  out  FEDWidth  to Frontend DataIn
- FEReturnReady  out  1  to Frontend ReturnDataReady
- FEReturnValid  in  1  Frontend ReturnDataValid
- FEReturnData  in  FEDWidth  Frontend ReturnData

## Operation
- State machine: Idle, Cmd, Data, Return.
- Store commands are Update and Append; each carries Beats data beats and returns nothing. Load commands are Read and ReadRmv; each carries no data and returns Beats beats.
- Idle:
  - Winner is the single valid requester. If both are valid, the winner is the requester that was not granted last; priority pointer LastGrant resets to 1, so requester 0 wins first.
  - CmdInReady_w = 1 for the winner only; the loser's ready = 0.
  - On handshake, latch {CmdIn, ProgAddrIn, WMaskIn} into a command register, set Owner = w and LastGrant = w, then go to Cmd.
- Cmd:
  - CmdOutValid = 1 and outputs are driven from the command register.
  - On CmdOutReady, go to Data if the command is a store, otherwise Return.
  - All CmdInReady_x = 0.
- Data:
  - Combinational pass-through: DataOut = DataIn_Owner, DataOutValid = DataInValid_Owner, DataInReady_Owner = DataOutReady.
  - The non-owner's DataInReady = 0.
  - BeatCount increments on each DataOut handshake. The handshake with BeatCount = Beats-1 clears the count and goes to Idle.
- Return:
  - Pass-through: ReturnData_Owner = FEReturnData, ReturnDataValid_Owner = FEReturnValid, FEReturnReady = ReturnDataReady_Owner.
  - The non-owner's ReturnDataValid = 0.
  - Beat counting and the exit to Idle work as in Data.
- Outside its owning state, every pass-through valid/ready is 0. Early DataInValid or stray FEReturnValid is therefore backpressured, never dropped.
- BeatCount is log2(Beats) bits wide and never exceeds Beats-1. A requester holding valid across a grant to the other requester must keep its command stable.

## Timing
- Reset values:
  - State = Idle, BeatCount = 0, LastGrant = 1, command register = 0.
  - All valid outputs = 0, FEReturnReady = 0, all DataInReady = 0.
  - CmdInReady_x is combinational and may be 1 in the first Idle cycle.
- Reset asserted mid-transaction returns the block to Idle on the next edge. The partial transfer is abandoned, and the Frontend is reset alongside it.
- Command latency: accept at cycle t, CmdOutValid from t+1.
- Transition: CmdOut handshake at cycle c, Data/Return pass-through from c+1.
- Data and return pass-throughs add zero latency; one beat per cycle is possible.
- Re-arbitration: the last beat completes at cycle d, Idle is entered at d+1, and the next CmdInReady can be asserted at d+1. Minimum store transaction is 2+Beats cycles.
- CmdInValid_1 rising while requester 0 is in Data has no effect until Idle.

## Test plan
- Beats = 8. Requester 0 sends Update, addr 0x10, 8 beats 0x1..0x8 → CmdOut = Update, ProgAddrOut = 0x10, DataOut beats 1..8 in order; back in Idle 1 cycle after the 8th beat.
- Both requesters valid in Idle after reset → requester 0 granted. After its transaction ends, with both still valid, requester 1 is granted; alternation continues 0,1,0,1.
- Requester 1 issues Read → FEReturnData beats 0xA0..0xA7 appear on ReturnData_1 only; ReturnDataValid_0 stays 0. Dropping ReturnDataReady_1 for 3 cycles drops FEReturnReady for the same 3 cycles and the beat count holds.
- DataOutReady low for 5 cycles mid-transfer → DataInReady_0 low for those cycles; exactly 8 handshakes total; no beat lost or duplicated.
- Requester 0 asserts DataInValid before its command is accepted → DataInReady_0 = 0 until state Data.
- Reset asserted at beat 4 of a Read → the next cycle is Idle with BeatCount = 0 and all outputs at reset values; a new Update completes normally.
